// File: rtl/led_pwm_dimmer.sv
// Multi-channel LED PWM dimmer: per-channel brightness targets with
// period-aligned updates and an optional one-step-per-FADE_DIV-periods ramp.
module led_pwm_dimmer #(
    parameter int unsigned N_CH     = 16,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned PRESC    = 784,
    parameter int unsigned FADE_DIV = 4,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   led_on,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DUTY_W-1:0] wr_duty,
    input  logic              fade_en,
    output logic [N_CH-1:0]   led_pwm,
    output logic              period_start,
    output logic              busy
);

    localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned FADE_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
    localparam logic [DUTY_W-1:0]  PWM_MAX    = DUTY_W'((1 << DUTY_W) - 2);
    localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_DIV - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic [DUTY_W-1:0]  pwm_cnt;
    logic [FADE_W-1:0]  fade_cnt;
    logic [DUTY_W-1:0]  cur [N_CH];
    logic [DUTY_W-1:0]  tgt [N_CH];

    logic tick;
    logic period_end;
    logic fade_step;

    // Timebase decode: PWM tick, last tick of the period, fade step period.
    always_comb begin
        tick       = (presc_cnt == PRESC_LAST);
        period_end = tick && (pwm_cnt == PWM_MAX);
        fade_step  = (fade_cnt == FADE_LAST);
    end

    // Prescaler, PWM counter and period-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= period_end;
            if (tick) begin
                presc_cnt <= '0;
                if (pwm_cnt == PWM_MAX) begin
                    pwm_cnt <= '0;
                end else begin
                    pwm_cnt <= pwm_cnt + DUTY_W'(1);
                end
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end

    // Fade period counter runs on every period boundary, ramp mode or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            fade_cnt <= '0;
        end else if (period_end) begin
            if (fade_step) begin
                fade_cnt <= '0;
            end else begin
                fade_cnt <= fade_cnt + FADE_W'(1);
            end
        end
    end

    // Target registers; an index with no matching channel writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                tgt[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (wr_ch == CH_W'(i)) begin
                    tgt[i] <= wr_duty;
                end
            end
        end
    end

    // Active duty changes only at a period boundary so a period is never cut.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                cur[i] <= '0;
            end
        end else if (period_end) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (!fade_en) begin
                    cur[i] <= tgt[i];
                end else if (fade_step) begin
                    if (cur[i] < tgt[i]) begin
                        cur[i] <= cur[i] + DUTY_W'(1);
                    end else if (cur[i] > tgt[i]) begin
                        cur[i] <= cur[i] - DUTY_W'(1);
                    end
                end
            end
        end
    end

    // Registered PWM compare; led_on gates without waiting for a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_pwm <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                led_pwm[i] <= led_on[i] && (pwm_cnt < cur[i]);
            end
        end
    end

    // Any channel still away from its target.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (cur[i] != tgt[i]) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench for led_pwm_dimmer: 4-channel, 3-bit duty, 14-clock period,
// plus a 3-channel build for the unused write index.
module tb_led_pwm_dimmer;

    localparam int unsigned PERIOD = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led_on;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [2:0] wr_duty;
    logic       fade_en;
    logic [3:0] led_pwm;
    logic       period_start;
    logic       busy;

    logic [2:0] led_on3;
    logic       wr_en3;
    logic [1:0] wr_ch3;
    logic [2:0] wr_duty3;
    logic       fade_en3;
    logic [2:0] led_pwm3;
    logic       period_start3;
    logic       busy3;

    int checks   = 0;
    int failures = 0;
    int nb       = 0;

    int         hi [4];
    logic [3:0] samp [PERIOD];
    logic       start_busy;

    int up_hi   [8] = '{0, 2, 2, 4, 4, 6, 6, 8};
    int up_busy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int dn_hi   [5] = '{6, 6, 4, 4, 2};
    int dn_busy [5] = '{1, 1, 1, 1, 0};
    int rs_hi   [4] = '{0, 2, 2, 4};

    led_pwm_dimmer #(.N_CH(4), .DUTY_W(3), .PRESC(2), .FADE_DIV(2)) u_dut (
        .clk(clk), .rst(rst), .led_on(led_on), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .fade_en(fade_en), .led_pwm(led_pwm),
        .period_start(period_start), .busy(busy)
    );

    led_pwm_dimmer #(.N_CH(3), .DUTY_W(3), .PRESC(2), .FADE_DIV(2)) u_dut3 (
        .clk(clk), .rst(rst), .led_on(led_on3), .wr_en(wr_en3), .wr_ch(wr_ch3),
        .wr_duty(wr_duty3), .fade_en(fade_en3), .led_pwm(led_pwm3),
        .period_start(period_start3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; count boundaries.
    task automatic step();
        @(posedge clk);
        #1;
        if (period_start) nb++;
    endtask

    task automatic wait_ps();
        for (int i = 0; i < 40; i++) begin
            if (period_start) break;
            step();
        end
        check("ps_wait", 32'(period_start), 1);
    endtask

    // Record one full period of outputs starting at a period_start sample.
    task automatic measure();
        int ps_cnt;
        wait_ps();
        start_busy = busy;
        ps_cnt = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int k = 0; k < int'(PERIOD); k++) begin
            step();
            samp[k] = led_pwm;
            for (int c = 0; c < 4; c++) hi[c] += int'(led_pwm[c]);
            ps_cnt += int'(period_start);
        end
        check("ps_spacing", 32'(ps_cnt), 1);
    endtask

    task automatic write_ch(input logic [1:0] ch, input logic [2:0] duty);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_duty = duty;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        int   steps;
        int   lowb;
        int   cnt;
        logic found;
        logic h4;

        rst = 1'b1; led_on = 4'hF; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; fade_en = 1'b0;
        led_on3 = 3'h7; wr_en3 = 1'b0; wr_ch3 = '0; wr_duty3 = '0; fade_en3 = 1'b0;
        repeat (3) step();
        check("rst_led", 32'(led_pwm), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ps", 32'(period_start), 0);
        rst = 1'b0;
        nb = 0;

        // 1: idle; first period_start 14 clocks after release
        steps = 0;
        while (!period_start && steps < 40) begin
            step();
            steps++;
        end
        check("first_ps_delay", 32'(steps), PERIOD);
        measure();
        check("idle_led", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 0);
        check("idle_busy", 32'(start_busy | busy), 0);

        // 2: jump mode writes mid-period
        repeat (3) step();
        write_ch(2'd0, 3'd3);
        write_ch(2'd1, 3'd7);
        check("jump_busy", 32'(busy), 1);
        lowb = 0;
        steps = 0;
        while (!period_start && steps < 20) begin
            if (!busy) lowb++;
            step();
            steps++;
        end
        check("jump_busy_hold", 32'(lowb), 0);
        check("jump_busy_drop", 32'(busy), 0);
        measure();
        check("ch0_first", 32'(samp[0][0]), 1);
        check("ch0_last_hi", 32'(samp[5][0]), 1);
        check("ch0_first_lo", 32'(samp[6][0]), 0);
        check("ch0_hi", 32'(hi[0]), 6);
        check("ch1_hi", 32'(hi[1]), 14);
        check("ch2_hi", 32'(hi[2]), 0);

        // 3: fade ch2 up to 4 then down to 1
        fade_en = 1'b1;
        write_ch(2'd2, 3'd4);
        for (int k = 0; k < 8; k++) begin
            measure();
            check($sformatf("up_hi%0d", k), 32'(hi[2]), 32'(up_hi[k]));
            check($sformatf("up_busy%0d", k), 32'(start_busy), 32'(up_busy[k]));
        end
        check("up_ch1_steady", 32'(hi[1]), 14);
        write_ch(2'd2, 3'd1);
        for (int k = 0; k < 5; k++) begin
            measure();
            check($sformatf("dn_hi%0d", k), 32'(hi[2]), 32'(dn_hi[k]));
            check($sformatf("dn_busy%0d", k), 32'(start_busy), 32'(dn_busy[k]));
        end

        // 4: write on the period_end clock takes effect one period later
        fade_en = 1'b0;
        repeat (13) step();
        write_ch(2'd3, 3'd5);
        check("pe_wr_ps", 32'(period_start), 1);
        check("pe_wr_busy", 32'(busy), 1);
        measure();
        check("pe_wr_old", 32'(hi[3]), 0);
        measure();
        check("pe_wr_new", 32'(hi[3]), 10);
        check("pe_wr_busy2", 32'(start_busy), 0);

        // 4b: index beyond the channel count on a 3-channel build
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_duty3 = 3'd7;
        step();
        wr_en3 = 1'b0;
        check("oor_busy", 32'(busy3), 0);
        cnt = 0;
        for (int k = 0; k < int'(PERIOD) + 2; k++) begin
            step();
            if (led_pwm3 != 3'b000 || busy3) cnt++;
        end
        check("oor_quiet", 32'(cnt), 0);
        wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_duty3 = 3'd5;
        step();
        wr_en3 = 1'b0;
        check("ch3b_busy", 32'(busy3), 1);
        repeat (PERIOD) step();
        check("ch3b_settle", 32'(busy3), 0);

        // 5: led_on gating mid high phase
        wait_ps();
        repeat (2) step();
        check("gate_pre", 32'(led_pwm[0]), 1);
        led_on = 4'hE;
        step();
        check("gate_off", 32'(led_pwm[0]), 0);
        check("gate_ch1", 32'(led_pwm[1]), 1);
        led_on = 4'hF;
        step();
        check("gate_on", 32'(led_pwm[0]), 1);
        measure();
        check("gate_cur", 32'(hi[0]), 6);

        // 6: reset in the middle of a ramp
        fade_en = 1'b1;
        write_ch(2'd2, 3'd4);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            wait_ps();
            repeat (4) step();
            h4 = led_pwm[2];
            step();
            if (h4 && !led_pwm[2]) found = 1'b1;
        end
        check("mid_cur2", 32'(found), 1);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        nb = 0;
        check("mrst_led", 32'(led_pwm), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_ps", 32'(period_start), 0);
        check("mrst_led3", 32'(led_pwm3), 0);
        check("mrst_busy3", 32'(busy3), 0);
        write_ch(2'd2, 3'd4);
        for (int k = 0; k < 4; k++) begin
            measure();
            check($sformatf("rs_hi%0d", k), 32'(hi[2]), 32'(rs_hi[k]));
        end
        check("rs_ch0", 32'(hi[0]), 0);
        check("rs_busy", 32'(start_busy), 1);
        fade_en = 1'b0;
        step();
        measure();
        check("fade_off_jump", 32'(hi[2]), 8);
        check("fade_off_busy", 32'(start_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pwm_dimmer.md
Name: led_pwm_dimmer

Overview:
Multi-channel LED brightness driver for the Basys3 LED bank. It generalises the fixed on/off 50% PWM driver to N independently dimmable channels. Each channel has a DUTY_W-bit brightness target written over a simple write port. An optional fade mode ramps brightness toward the target one step at a time. It sits between the control logic (e.g. servo-position-to-LED mapping) and the board LED pins.

Parameters:
N_CH, 16, number of LED channels (1..32)
DUTY_W, 8, brightness resolution in bits (2..12); PWM period = 2^DUTY_W-1 ticks
PRESC, 784, clocks per PWM tick (>=1); default gives 784*255 = 199920 clk, about 500 Hz at 100 MHz
FADE_DIV, 4, PWM periods per fade step (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
led_on  in  N_CH  per-channel enable mask; 0 forces that output low
wr_en  in  1  write strobe, one target write per asserted clock
wr_ch  in  max(1,$clog2(N_CH))  channel index for the write
wr_duty  in  DUTY_W  new brightness target
fade_en  in  1  1 = ramp mode, 0 = jump mode
led_pwm  out  N_CH  registered PWM outputs
period_start  out  1  one-clock pulse on the first clock of each PWM period
busy  out  1  1 while any channel's active duty differs from its target

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): prescaler, pwm_cnt, fade_cnt, every cur[i] and tgt[i], led_pwm, period_start all go to 0; busy reads 0. rst overrides every other input, including when asserted mid-period or mid-fade.
- Prescaler counts 0..PRESC-1 and wraps. tick = (presc_cnt == PRESC-1). PRESC=1 means tick is asserted every clock.
- pwm_cnt advances on tick over 0..MAX, with MAX = 2^DUTY_W-2, then wraps to 0. period_end = tick && pwm_cnt==MAX.
- period_start is registered and asserts on the clock after period_end, i.e. the first clock with pwm_cnt=0. It does not assert on the first period after reset.
- Per-channel registers: tgt[i] holds the written target; cur[i] holds the duty applied in the current period.
- Write: on wr_en, tgt[wr_ch] <= wr_duty at that edge. If wr_ch >= N_CH the write is ignored. The write never changes cur directly, so a period is never truncated or glitched.
- cur update happens only on period_end.
  - fade_en=0: cur[i] <= tgt[i].
  - fade_en=1: fade_cnt counts periods 0..FADE_DIV-1. When fade_cnt==FADE_DIV-1, each cur[i] steps by 1 toward tgt[i] (+1 if below, -1 if above, unchanged if equal). At other period_ends cur holds.
  - fade_cnt advances on every period_end regardless of fade_en.
  - Clearing fade_en mid-ramp makes cur jump to tgt at the next period_end.
- Write coinciding with period_end: cur uses the tgt value from before the edge. The new value takes effect at the following boundary.
- Output: led_pwm[i] <= led_on[i] && (pwm_cnt < cur[i]), registered, so one clock of latency behind pwm_cnt.
  - duty 0 gives constant low.
  - duty 2^DUTY_W-1 gives constant high, with no dropout at wrap.
  - High time = cur*PRESC clocks per period.
- led_on acts immediately (next clock) and is not synchronised to the period.
- busy = OR over i of (cur[i] != tgt[i]), decoded directly from registers with no extra latency.
- All arithmetic is unsigned. cur never over- or underflows because it only steps toward tgt.

Test Plan:
Use a bench with N_CH=4, DUTY_W=3, PRESC=2, FADE_DIV=2, which gives a 14-clock period.
1. Reset then idle, led_on=4'hF -> led_pwm=0 and busy=0 forever; period_start pulses every 14 clocks.
2. fade_en=0, write ch0=3 and ch1=7 mid-period -> busy=1 until the next period_end. In the following period, ch0 is high for exactly 6 consecutive clocks starting 1 clock after pwm_cnt=0. ch1 stays high continuously across the wrap.
3. fade_en=1, write ch2=4 from 0 -> cur[2] goes 1,2,3,4, one step every 2 periods (28 clocks). Then write ch2=1 -> cur[2] ramps down 3,2,1 and busy drops when cur[2]=1.
4. Write ch3=5 on the exact clock of period_end -> cur[3] remains at its old value for one period and becomes 5 at the next boundary. Write with wr_ch=4 or higher (sized port, N_CH=4 bench uses a 2-bit index, so exercise it with a N_CH=3 build) -> no register changes.
5. ch0 at duty 3, toggle led_on[0] 1->0->1 mid-high-phase -> led_pwm[0] drops and returns on the next clock each time; cur[0] is unaffected.
6. Assert rst for 1 clock mid-fade with cur[2]=2 and tgt[2]=4 -> the next clock shows all outputs 0 and busy=0. A fresh write of 4 then ramps from 0.
